// File: rtl/pipe_stage_buffer.sv
// Elastic inter-stage pipeline buffer: DEPTH-entry ring of {ctrl, data} with valid/ready on both sides,
// bubble-inserting flush, single-step gating and a saturating back-pressure counter for the debug unit.
module pipe_stage_buffer #(
  parameter int                 NB_DATA     = 128,
  parameter int                 NB_CTRL     = 16,
  parameter int                 DEPTH       = 2,
  parameter logic [NB_CTRL-1:0] CTRL_BUBBLE = '0,
  parameter int                 NB_CNT      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_step,
  input  logic                     i_flush,
  input  logic                     i_in_valid,
  input  logic [NB_DATA-1:0]       i_in_data,
  input  logic [NB_CTRL-1:0]       i_in_ctrl,
  output logic                     o_in_ready,
  output logic                     o_out_valid,
  output logic [NB_DATA-1:0]       o_out_data,
  output logic [NB_CTRL-1:0]       o_out_ctrl,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [NB_CNT-1:0]        o_stall_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipe_stage_buffer: DEPTH must be a power of two between 2 and 8");
  end

  typedef struct packed {
    logic [NB_CTRL-1:0] ctrl;
    logic [NB_DATA-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [NB_CNT-1:0] stall_q;

  logic push;
  logic pop;
  logic stall_evt;
  logic stall_sat;

  // Full/empty come from the occupancy counter only; rd_ptr == wr_ptr is ambiguous.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_out_data  = '0;
    o_out_ctrl  = CTRL_BUBBLE;
    o_in_ready  = (count_q != FULL);
    o_out_valid = (count_q != '0);
    if (o_out_valid) begin
      o_out_data = mem[rd_ptr].data;
      o_out_ctrl = mem[rd_ptr].ctrl;
    end
  end

  assign o_count       = count_q;
  assign o_stall_count = stall_q;

  // i_step gates every transfer; flush wins over both sides so the entry at that edge is dropped.
  assign push      = i_in_valid  & o_in_ready  & i_step & ~i_flush;
  assign pop       = o_out_valid & i_out_ready & i_step & ~i_flush;
  assign stall_evt = o_out_valid & ~i_out_ready & i_step & ~i_flush;
  assign stall_sat = (stall_q == {NB_CNT{1'b1}});

  // All state moves on the falling edge, like the original pipeline registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge i_clk) begin
    if (!i_reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else if (i_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (stall_evt && !stall_sat) stall_q <= stall_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; o_out_data is masked to 0 whenever count is 0.
  always_ff @(negedge i_clk) begin
    if (push) mem[wr_ptr] <= '{ctrl: i_in_ctrl, data: i_in_data};
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: reset, fill/back-pressure, streaming wrap, flush,
// step freeze and stall-counter saturation, all with hand-computed expectations.
module tb_pipe_stage_buffer;

  localparam int NB_DATA = 32;
  localparam int NB_CTRL = 8;
  localparam int DEPTH   = 2;
  localparam int NB_CNT  = 4;
  localparam logic [NB_CTRL-1:0] BUBBLE = 8'hE0;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               step;
  logic               flush;
  logic               in_valid;
  logic [NB_DATA-1:0] in_data;
  logic [NB_CTRL-1:0] in_ctrl;
  logic               in_ready;
  logic               out_valid;
  logic [NB_DATA-1:0] out_data;
  logic [NB_CTRL-1:0] out_ctrl;
  logic               out_ready;
  logic [1:0]         count;
  logic [NB_CNT-1:0]  stall_count;

  int checks = 0;
  int errors = 0;

  pipe_stage_buffer #(
    .NB_DATA    (NB_DATA),
    .NB_CTRL    (NB_CTRL),
    .DEPTH      (DEPTH),
    .CTRL_BUBBLE(BUBBLE),
    .NB_CNT     (NB_CNT)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_step       (step),
    .i_flush      (flush),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .i_in_ctrl    (in_ctrl),
    .o_in_ready   (in_ready),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .o_out_ctrl   (out_ctrl),
    .i_out_ready  (out_ready),
    .o_count      (count),
    .o_stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // The DUT updates on the falling edge; inputs change and outputs are sampled at the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      @(posedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [NB_DATA-1:0] d, input logic [NB_CTRL-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    step      = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 8'h01);

    // Reset held two edges with an upstream entry present.
    tick(2);
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", out_ctrl, BUBBLE);
    check("rst_data", out_data, 0);
    check("rst_count", count, 0);
    check("rst_stall", stall_count, 0);
    check("rst_in_ready", in_ready, 1);

    // First push appears one edge later.
    reset_n = 1'b1;
    drive(1'b1, 32'hA5, 8'h0A);
    tick();
    check("first_data", out_data, 32'hA5);
    check("first_ctrl", out_ctrl, 8'h0A);
    check("first_count", count, 1);
    check("first_stall", stall_count, 0);

    // Reset mid-transfer discards the entry and masks the data.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_count", count, 0);
    check("midrst_data", out_data, 0);

    // Fill with back-pressure.
    drive(1'b1, 32'h11, 8'h11);
    tick();
    check("fill1_count", count, 1);
    check("fill1_stall", stall_count, 0);
    drive(1'b1, 32'h22, 8'h22);
    tick();
    check("fill2_count", count, 2);
    check("fill2_in_ready", in_ready, 0);
    check("fill2_head", out_data, 32'h11);
    check("fill2_stall", stall_count, 1);
    drive(1'b1, 32'h33, 8'h33);
    tick();
    check("full_hold_count", count, 2);
    check("full_hold_head", out_data, 32'h11);
    check("full_hold_stall", stall_count, 2);

    // Pop while full: 0x33 is not passed through at that edge.
    out_ready = 1'b1;
    tick();
    check("pop_full_count", count, 1);
    check("pop_full_head", out_data, 32'h22);
    check("pop_full_stall", stall_count, 2);
    tick();
    check("pushpop_count", count, 1);
    check("pushpop_head", out_data, 32'h33);
    drive(1'b0, 32'h0, 8'h0);
    tick();
    check("drain_count", count, 0);
    check("drain_ctrl", out_ctrl, BUBBLE);
    check("drain_data", out_data, 0);

    // Streaming 1..10: pointers wrap repeatedly, occupancy stays 1.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, NB_DATA'(i), NB_CTRL'(i));
      tick();
      check("stream_data", out_data, 64'(i));
      check("stream_ctrl", out_ctrl, 64'(i));
      check("stream_count", count, 1);
    end
    drive(1'b0, 32'h0, 8'h0);
    tick();
    check("stream_end_count", count, 0);
    check("stream_end_stall", stall_count, 2);

    // Flush with two entries buffered and 0x44 offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h66, 8'h66);
    tick();
    drive(1'b1, 32'h77, 8'h77);
    tick();
    check("preflush_count", count, 2);
    check("preflush_stall", stall_count, 3);
    drive(1'b1, 32'h44, 8'h44);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_ctrl", out_ctrl, BUBBLE);
    check("flush_valid", out_valid, 0);
    check("flush_stall", stall_count, 3);
    drive(1'b1, 32'h55, 8'h55);
    tick();
    check("postflush_head", out_data, 32'h55);
    check("postflush_count", count, 1);
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 8'h0);
    tick();
    check("postflush_drain", count, 0);

    // Step freeze: nothing moves for five edges, then a flush still empties.
    out_ready = 1'b0;
    drive(1'b1, 32'h88, 8'h88);
    tick();
    drive(1'b1, 32'h99, 8'h99);
    tick();
    check("prefreeze_stall", stall_count, 4);
    step      = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hBB, 8'hBB);
    tick(5);
    check("freeze_count", count, 2);
    check("freeze_head", out_data, 32'h88);
    check("freeze_stall", stall_count, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("freeze_flush_count", count, 0);
    check("freeze_flush_ctrl", out_ctrl, BUBBLE);
    step = 1'b1;

    // Saturation of the 4-bit stall counter: 4 + 20 stalled edges clamps at 15.
    out_ready = 1'b0;
    drive(1'b1, 32'hCC, 8'hCC);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    check("sat_start", stall_count, 4);
    tick(20);
    check("sat_value", stall_count, 15);
    tick(3);
    check("sat_hold", stall_count, 15);
    check("sat_head", out_data, 32'hCC);

    // Only reset clears the stall counter.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("final_rst_stall", stall_count, 0);
    check("final_rst_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
